// File: rtl/raster_scan_gen_pkg.sv
// Shared types and default sizes for the raster scan generator.
package scan_pkg;

  localparam int DEF_MAX_W     = 1024;
  localparam int DEF_MAX_H     = 1024;
  localparam int DEF_ADDR_BITS = 20;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_e;

  typedef enum logic {
    MODE_RASTER     = 1'b0,
    MODE_SERPENTINE = 1'b1
  } scan_mode_e;

endpackage

// File: rtl/raster_scan_gen_axis.sv
// One scan axis: up/down counter with load and a terminal-count flag.
// Terminal count is the limit when counting up and zero when counting down.
module scan_axis
  import scan_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir_down,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over stepping; stepping direction chosen per row by the caller.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = dir_down ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = dir_down ? (cnt_q == '0) : (cnt_q == limit);

endmodule

// File: rtl/raster_scan_gen.sv
// Runtime-configurable 2D scan generator: one (x, y, address) beat per
// accepted handshake, raster or serpentine order, with repeat and abort.
// The address is tracked incrementally (row base + stride per row, +/-1
// within a row) so no multiplier is needed.
module raster_scan_gen
  import scan_pkg::*;
#(
  parameter int MAX_W     = DEF_MAX_W,
  parameter int MAX_H     = DEF_MAX_H,
  parameter int X_BITS    = $clog2(MAX_W),
  parameter int Y_BITS    = $clog2(MAX_H),
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [X_BITS-1:0]    cfg_w_m1,
  input  logic [Y_BITS-1:0]    cfg_h_m1,
  input  logic                 cfg_mode,
  input  logic                 cfg_repeat,
  input  logic [ADDR_BITS-1:0] cfg_base,
  input  logic [ADDR_BITS-1:0] cfg_stride,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [X_BITS-1:0]    out_x,
  output logic [Y_BITS-1:0]    out_y,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic                 out_sol,
  output logic                 out_eol,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  scan_state_e            state_q, state_d;
  logic                   done_q, done_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [ADDR_BITS-1:0]   row_base_q, row_base_d;

  // Latched frame configuration (data only, not reset).
  logic [X_BITS-1:0]      w_m1_q, w_m1_d;
  logic [Y_BITS-1:0]      h_m1_q, h_m1_d;
  scan_mode_e             mode_q, mode_d;
  logic                   repeat_q, repeat_d;
  logic [ADDR_BITS-1:0]   base_q, base_d;
  logic [ADDR_BITS-1:0]   stride_q, stride_d;

  logic                   x_load, x_en, x_tc;
  logic [X_BITS-1:0]      x_load_val, x_cnt, x_row_next;
  logic                   y_load, y_en, y_tc;
  logic [Y_BITS-1:0]      y_cnt;
  logic                   run, accept, row_rev, eol, last;

  assign run     = (state_q == RUN);
  assign accept  = run && out_ready;
  // Odd rows of a serpentine frame scan right-to-left.
  assign row_rev = (mode_q == MODE_SERPENTINE) && y_cnt[0];
  assign eol     = run && x_tc;
  assign last    = eol && y_tc;
  // Serpentine keeps x across the row step; raster returns to column 0.
  assign x_row_next = (mode_q == MODE_SERPENTINE) ? x_cnt : '0;

  scan_axis #(.W(X_BITS)) u_x_axis (
    .clk      (clk),
    .rst      (rst),
    .load     (x_load),
    .load_val (x_load_val),
    .en       (x_en),
    .dir_down (row_rev),
    .limit    (w_m1_q),
    .cnt      (x_cnt),
    .tc       (x_tc)
  );

  scan_axis #(.W(Y_BITS)) u_y_axis (
    .clk      (clk),
    .rst      (rst),
    .load     (y_load),
    .load_val ('0),
    .en       (y_en),
    .dir_down (1'b0),
    .limit    (h_m1_q),
    .cnt      (y_cnt),
    .tc       (y_tc)
  );

  // Next state, config latch, counter controls and address stepping.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    w_m1_d     = w_m1_q;
    h_m1_d     = h_m1_q;
    mode_d     = mode_q;
    repeat_d   = repeat_q;
    base_d     = base_q;
    stride_d   = stride_q;
    x_load     = 1'b0;
    x_load_val = '0;
    x_en       = 1'b0;
    y_load     = 1'b0;
    y_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = RUN;
          w_m1_d     = cfg_w_m1;
          h_m1_d     = cfg_h_m1;
          mode_d     = scan_mode_e'(cfg_mode);
          repeat_d   = cfg_repeat;
          base_d     = cfg_base;
          stride_d   = cfg_stride;
          x_load     = 1'b1;
          y_load     = 1'b1;
          addr_d     = cfg_base;
          row_base_d = cfg_base;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (last) begin
            // Frame complete: rewind to (0,0) for either repeat or next start.
            done_d     = 1'b1;
            state_d    = repeat_q ? RUN : IDLE;
            x_load     = 1'b1;
            y_load     = 1'b1;
            addr_d     = base_q;
            row_base_d = base_q;
          end else if (x_tc) begin
            y_en       = 1'b1;
            x_load     = 1'b1;
            x_load_val = x_row_next;
            addr_d     = row_base_q + stride_q + ADDR_BITS'(x_row_next);
            row_base_d = row_base_q + stride_q;
          end else begin
            x_en   = 1'b1;
            addr_d = row_rev ? (addr_q - ADDR_BITS'(1)) : (addr_q + ADDR_BITS'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      addr_q     <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
    end
  end

  // Frame configuration registers.
  always_ff @(posedge clk) begin
    w_m1_q   <= w_m1_d;
    h_m1_q   <= h_m1_d;
    mode_q   <= mode_d;
    repeat_q <= repeat_d;
    base_q   <= base_d;
    stride_q <= stride_d;
  end

  assign out_valid = run;
  assign busy      = run;
  assign done      = done_q;
  assign out_x     = x_cnt;
  assign out_y     = y_cnt;
  assign out_addr  = addr_q;
  assign out_sol   = run && (row_rev ? (x_cnt == w_m1_q) : (x_cnt == '0));
  assign out_eol   = eol;
  assign out_last  = last;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Directed bench for raster_scan_gen.
module tb_raster_scan_gen;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int AB = 20;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [XB-1:0] cfg_w_m1;
  logic [YB-1:0] cfg_h_m1;
  logic          cfg_mode, cfg_repeat;
  logic [AB-1:0] cfg_base, cfg_stride;
  logic          out_valid, out_ready;
  logic [XB-1:0] out_x;
  logic [YB-1:0] out_y;
  logic [AB-1:0] out_addr;
  logic          out_sol, out_eol, out_last, busy, done;

  int total = 0;
  int bad   = 0;

  raster_scan_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_w_m1(cfg_w_m1), .cfg_h_m1(cfg_h_m1), .cfg_mode(cfg_mode),
    .cfg_repeat(cfg_repeat), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_addr(out_addr), .out_sol(out_sol), .out_eol(out_eol),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Beat vector: {valid, busy, x, y, addr, sol, eol, last}
  logic [44:0] got, exp;
  assign got = {out_valid, busy, out_x, out_y, out_addr, out_sol, out_eol, out_last};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int wm1, input int hm1, input bit mode, input bit rep,
                          input logic [AB-1:0] base, input logic [AB-1:0] stride);
    cfg_w_m1 = XB'(wm1); cfg_h_m1 = YB'(hm1); cfg_mode = mode; cfg_repeat = rep;
    cfg_base = base; cfg_stride = stride;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_w_m1 = '0; cfg_h_m1 = '0; cfg_mode = 1'b0; cfg_repeat = 1'b0;
    cfg_base = '0; cfg_stride = '0;
    tick(); tick();
    total++;
    if ({got, done} !== 46'd0) begin
      bad++; $display("FAIL reset_outputs: got %h done=%b want 0", got, done);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({got, done} !== 46'd0) begin
      bad++; $display("FAIL reset_idle: got %h done=%b want 0", got, done);
    end
  endtask

  task automatic test_raster();
    logic [AB-1:0] ea [8];
    ea = '{20'h100, 20'h101, 20'h102, 20'h103, 20'h110, 20'h111, 20'h112, 20'h113};
    out_ready = 1'b1;
    do_start(3, 1, 1'b0, 1'b0, 20'h100, 20'h10);
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, 1'b1, XB'(i % 4), YB'(i / 4), ea[i], i % 4 == 0, i % 4 == 3, i == 7};
      total++;
      if (got !== exp || done !== 1'b0) begin
        bad++; $display("FAIL raster_beat%0d: got %h done=%b want %h done=0", i, got, done, exp);
      end
      tick();
    end
    total++;
    if ({done, out_valid, busy} !== 3'b100) begin
      bad++; $display("FAIL raster_done: got done/valid/busy=%b%b%b want 100", done, out_valid, busy);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL raster_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_serpentine();
    logic [AB-1:0] ea [8];
    int xs [8];
    ea = '{20'h100, 20'h101, 20'h102, 20'h103, 20'h113, 20'h112, 20'h111, 20'h110};
    xs = '{0, 1, 2, 3, 3, 2, 1, 0};
    out_ready = 1'b1;
    do_start(3, 1, 1'b1, 1'b0, 20'h100, 20'h10);
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, 1'b1, XB'(xs[i]), YB'(i / 4), ea[i], i == 0 || i == 4, i == 3 || i == 7, i == 7};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL serp_beat%0d: got %h want %h", i, got, exp);
      end
      tick();
    end
    total++;
    if ({done, out_valid} !== 2'b10) begin
      bad++; $display("FAIL serp_done: got done/valid=%b%b want 10", done, out_valid);
    end
    tick();
  endtask

  task automatic test_stall();
    int k = 0;
    int stalls = 0;
    do_start(4, 2, 1'b0, 1'b0, 20'h40, 20'h20);
    for (int cyc = 0; cyc < 300 && out_valid; cyc++) begin
      exp = {1'b1, 1'b1, XB'(k % 5), YB'(k / 5), AB'(20'h40 + (k / 5) * 20'h20 + k % 5),
             k % 5 == 0, k % 5 == 4, k == 14};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL stall_beat%0d: got %h want %h", k, got, exp);
      end
      out_ready = (cyc % 7 == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (out_ready) k++;
      else stalls++;
      tick();
    end
    total++;
    if (out_valid !== 1'b0 || k != 15 || done !== 1'b1) begin
      bad++; $display("FAIL stall_count: got valid=%b accepts=%0d done=%b want 0 15 1", out_valid, k, done);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_repeat();
    logic [AB-1:0] ea [4];
    int dones = 0;
    ea = '{20'h200, 20'h201, 20'h204, 20'h205};
    out_ready = 1'b1;
    do_start(1, 1, 1'b0, 1'b1, 20'h200, 20'h4);
    for (int i = 0; i < 12; i++) begin
      exp = {1'b1, 1'b1, XB'(i % 2), YB'((i % 4) / 2), ea[i % 4], 1'(i % 2 == 0), 1'(i % 2 == 1), i % 4 == 3};
      total++;
      if (got !== exp || done !== 1'((i > 0) && (i % 4 == 0))) begin
        bad++; $display("FAIL repeat_beat%0d: got %h done=%b want %h", i, got, done, exp);
      end
      if (done === 1'b1) dones++;
      tick();
    end
    if (done === 1'b1) dones++;
    total++;
    if (dones != 3 || {out_valid, busy, out_x, out_y} !== {2'b11, XB'(0), YB'(0)}) begin
      bad++; $display("FAIL repeat_dones: got dones=%0d valid=%b x=%0d y=%0d want 3 1 0 0", dones, out_valid, out_x, out_y);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({out_valid, busy, done} !== 3'b000) begin
      bad++; $display("FAIL repeat_abort: got valid/busy/done=%b%b%b want 000", out_valid, busy, done);
    end
  endtask

  task automatic test_abort_start_rst();
    out_ready = 1'b1;
    do_start(3, 1, 1'b0, 1'b0, 20'h100, 20'h10);
    tick(); tick(); tick();
    total++;
    if (out_x !== XB'(3) || out_addr !== 20'h103) begin
      bad++; $display("FAIL abort_pre: got x=%0d addr=%h want 3 103", out_x, out_addr);
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    total++;
    if ({out_valid, busy, done} !== 3'b000) begin
      bad++; $display("FAIL abort_now: got valid/busy/done=%b%b%b want 000", out_valid, busy, done);
    end
    tick();
    total++;
    if ({out_valid, busy, done} !== 3'b000) begin
      bad++; $display("FAIL abort_start_ignored: got valid/busy/done=%b%b%b want 000", out_valid, busy, done);
    end
    // start while running, with new config on the inputs
    do_start(3, 1, 1'b0, 1'b0, 20'h100, 20'h10);
    tick(); tick();
    cfg_w_m1 = '0; cfg_base = 20'h900; cfg_stride = '0; cfg_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp = {1'b1, 1'b1, XB'(3), YB'(0), 20'h103, 1'b0, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL run_start_beat3: got %h want %h", got, exp);
    end
    tick();
    exp = {1'b1, 1'b1, XB'(0), YB'(1), 20'h110, 1'b1, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL run_start_beat4: got %h want %h", got, exp);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({got, done} !== 46'd0) begin
      bad++; $display("FAIL rst_mid: got %h done=%b want 0", got, done);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({got, done} !== 46'd0) begin
      bad++; $display("FAIL rst_mid_idle: got %h done=%b want 0", got, done);
    end
  endtask

  task automatic test_edges();
    out_ready = 1'b1;
    do_start(0, 0, 1'b0, 1'b0, 20'h55, 20'h10);
    exp = {1'b1, 1'b1, XB'(0), YB'(0), 20'h55, 1'b1, 1'b1, 1'b1};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL one_by_one: got %h want %h", got, exp);
    end
    tick();
    total++;
    if ({done, out_valid} !== 2'b10) begin
      bad++; $display("FAIL one_by_one_done: got done/valid=%b%b want 10", done, out_valid);
    end
    // start in the done cycle is honoured
    do_start(0, 0, 1'b0, 1'b0, 20'h66, 20'h10);
    total++;
    if ({out_valid, out_addr, out_last} !== {1'b1, 20'h66, 1'b1}) begin
      bad++; $display("FAIL start_at_done: got valid=%b addr=%h want 1 66", out_valid, out_addr);
    end
    tick();
    tick();
    // full-width single row with address wrap
    do_start(1023, 0, 1'b0, 1'b0, 20'hFFF00, 20'h400);
    for (int i = 0; i < 1024; i++) begin
      exp = {1'b1, 1'b1, XB'(i), YB'(0), AB'(20'hFFF00 + AB'(i)), i == 0, i == 1023, i == 1023};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL wide_beat%0d: got %h want %h", i, got, exp);
      end
      tick();
    end
    total++;
    if ({done, out_valid} !== 2'b10) begin
      bad++; $display("FAIL wide_done: got done/valid=%b%b want 10", done, out_valid);
    end
    tick();
    // width-1 serpentine column
    do_start(0, 2, 1'b1, 1'b0, 20'h10, 20'h100);
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 1'b1, XB'(0), YB'(i), AB'(20'h10 + 20'h100 * i), 1'b1, 1'b1, i == 2};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL column_beat%0d: got %h want %h", i, got, exp);
      end
      tick();
    end
    total++;
    if ({done, out_valid, busy} !== 3'b100) begin
      bad++; $display("FAIL column_done: got done/valid/busy=%b%b%b want 100", done, out_valid, busy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_raster();
    test_serpentine();
    test_stall();
    test_repeat();
    test_abort_start_rst();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/raster_scan_gen.md
# raster_scan_gen

Runtime-configurable 2D scan generator producing one (x, y, linear address) beat per accepted handshake across a rectangular frame. It sits between the frame-level control and pixel consumers: framebuffer readers, sprite blitters and fill engines. It generalises the fixed-size 2D counter with:
- size set at start time rather than at elaboration,
- raster or serpentine ordering,
- a strided linear address,
- valid/ready back-pressure,
- one-shot or free-running frames, with abort.

## Interface
Parameters:
- MAX_W, 1024, largest supported frame width in pixels.
- MAX_H, 1024, largest supported frame height in lines.
- X_BITS, $clog2(MAX_W), width of x coordinate and of cfg_w_m1.
- Y_BITS, $clog2(MAX_H), width of y coordinate and of cfg_h_m1.
- ADDR_BITS, 20, width of linear address, stride and base.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; latches cfg_* and begins a frame. Honoured only in IDLE.
- abort  in  1  returns to IDLE next cycle; no done pulse.
- cfg_w_m1  in  X_BITS  frame width minus one.
- cfg_h_m1  in  Y_BITS  frame height minus one.
- cfg_mode  in  1  0 = raster, 1 = serpentine (odd rows scan right-to-left).
- cfg_repeat  in  1  1 = restart automatically after each frame.
- cfg_base  in  ADDR_BITS  address of pixel (0,0).
- cfg_stride  in  ADDR_BITS  address increment per row.
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_x  out  X_BITS  current x.
- out_y  out  Y_BITS  current y.
- out_addr  out  ADDR_BITS  cfg_base + y*cfg_stride + x, modulo 2^ADDR_BITS.
- out_sol  out  1  first beat of a row in scan order.
- out_eol  out  1  last beat of a row in scan order.
- out_last  out  1  final beat of the frame.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse after the final beat of a frame is accepted.

## Operation
- FSM states: IDLE, RUN.
  - IDLE→RUN on start && !abort. Config is latched into internal registers; later cfg_* changes are ignored until the next start.
  - RUN→IDLE on abort, or on acceptance of an out_last beat when the latched repeat is 0.
  - RUN stays in RUN on out_last acceptance when repeat is 1: coordinates return to (0,0), done still pulses, and there is no idle gap.
- Beat advance happens only on acceptance. While out_valid && !out_ready, all out_* hold stable.
- Raster order: x counts 0..w_m1, then x=0 and y+1.
- Serpentine order: even rows run x 0→w_m1; odd rows run w_m1→0. Row-to-row steps keep x and change y only.
- Address is maintained incrementally, with no multiplier:
  - a row_base register advances by stride per row;
  - out_addr is stepped by ±1 within a row;
  - on a row change, out_addr = row_base + stride + next x.
- All arithmetic is modulo 2^ADDR_BITS; there is no overflow detection.
- Flag definitions:
  - out_sol/out_eol are defined in scan order, not by x value.
  - Width 1 (w_m1=0): sol=eol=1 on every beat.
  - Size 1×1: the single beat has sol=eol=last=1.
- Simultaneous events:
  - abort has priority over start and over acceptance;
  - start during RUN is ignored;
  - rst overrides everything.

## Timing
- Reset values: out_valid=0, busy=0, done=0; out_x=0, out_y=0, out_addr=0; out_sol=0, out_eol=0, out_last=0. State is IDLE.
- start sampled in cycle n → out_valid=1 in n+1 with (0,0) and out_addr=cfg_base. busy=1 from n+1.
- Throughput is one beat per cycle while out_ready=1. Accepting at cycle k presents the next beat at k+1.
- out_last accepted at cycle m:
  - done=1 at m+1 only.
  - One-shot: out_valid=0 and busy=0 at m+1; a start at m+1 is honoured.
  - Repeat: (0,0) is presented at m+1.
- abort at cycle a → out_valid=0 and busy=0 at a+1; done stays 0.
- All outputs are registered. There is no combinational path from out_ready to out_valid or to the beat fields.

## Structure
- Package scan_pkg holds:
  - enum scan_state_e {IDLE, RUN};
  - enum scan_mode_e {MODE_RASTER=0, MODE_SERPENTINE=1};
  - the default width localparams.
- Sub-module scan_axis: parametrised-width up/down counter with load, terminal-count flag and direction input. Two instances, one for x and one for y; the top holds the FSM, the address datapath and the flags.

## Test plan
- Reset, then start with w_m1=3, h_m1=1, raster, base=0x100, stride=0x10, ready=1 → 8 beats with addr 0x100..0x103, 0x110..0x113; last on beat 8; done one cycle later; busy low.
- Same frame in serpentine mode → x order 0,1,2,3,3,2,1,0; second-row addr 0x113..0x110; sol/eol on beats 1/4/5/8.
- Random out_ready stalls on a 5×3 frame → beats stay stable while stalled; exactly 15 acceptances; no beat duplicated or skipped.
- Repeat=1 on a 2×2 frame over 3 frames → done pulses 3 times; (0,0) follows each last beat with no gap; busy stays 1.
- abort mid-frame with a simultaneous start; start during RUN; rst mid-frame → IDLE next cycle, no done, start ignored, all outputs at reset values.
- 1×1 frame and a MAX_W×1 frame → sol/eol/last all set on the 1×1 beat; address wraps correctly when base + MAX_W exceeds 2^ADDR_BITS.
